radarpim_reset_sequencer: RTL and testbench
===========================================

Name: radarpim_reset_sequencer

Overview:
- Consumer-side companion to the system clock PLL wrapper; runs on the PLL output clock.
- Watches the PLL lock indication and generates sequenced, registered active-low resets for the system: core first, then peripherals.
- Also handles software-requested warm resets and counts lock-loss events.
- Sits directly after the clock PLL block in the top-level clock/reset tree.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising pll_locked; legal range 2..4.
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before core reset release; ≥1.
- CORE_TO_PERI_DELAY, 16: cycles between rstnn_core release and rstnn_peri release; ≥1.
- SW_RESET_CYCLES, 64: cycles both resets are held low after a software request; ≥1.
- CNT_WIDTH, 16: width of the shared sequence counter. It must hold max(LOCK_STABLE_CYCLES, CORE_TO_PERI_DELAY, SW_RESET_CYCLES)-1.

Ports:
- clk  input  1  system clock (PLL output)
- rst  input  1  synchronous, active-high reset
- pll_locked  input  1  PLL lock flag; asynchronous to clk
- sw_reset_req  input  1  single-cycle warm-reset request, synchronous to clk
- rstnn_core  output  1  active-low core reset, registered
- rstnn_peri  output  1  active-low peripheral reset, registered
- system_ready  output  1  high when both resets are released
- lock_loss_count  output  8  saturating count of lock-loss events
- seq_state  output  3  current FSM state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it is sampled only on the rising edge of clk.
- While rst=1 at an edge:
  - state becomes WAIT_LOCK;
  - synchroniser flops, counter and lock_loss_count clear to 0;
  - rstnn_core=0, rstnn_peri=0, system_ready=0, seq_state=0.
- Synchronisation: pll_locked passes through SYNC_STAGES flops to produce locked_sync. No other logic uses pll_locked directly.
- Lock-loss counting: lock_loss_count increments on every locked_sync 1->0 transition and saturates at 255.
- All outputs are registers updated on the same edge as the state register. Their values are a function of the next state.
- FSM states and encodings (seq_state): WAIT_LOCK=0, STABLE=1, CORE_RUN=2, RUN=3, SW_RESET=4.
- WAIT_LOCK:
  - both resets low, counter=0;
  - locked_sync=1 -> STABLE.
- STABLE:
  - both resets low; counter increments each cycle;
  - counter==LOCK_STABLE_CYCLES-1 -> CORE_RUN with counter=0.
- CORE_RUN:
  - rstnn_core=1, rstnn_peri=0; counter increments;
  - counter==CORE_TO_PERI_DELAY-1 -> RUN with counter=0.
- RUN:
  - rstnn_core=1, rstnn_peri=1, system_ready=1; counter held at 0.
- SW_RESET:
  - both resets low, system_ready=0; counter increments;
  - counter==SW_RESET_CYCLES-1 -> CORE_RUN with counter=0.
  - Lock stability is not re-qualified on exit.
- sw_reset_req:
  - honoured only in CORE_RUN or RUN -> SW_RESET with counter=0; both resets go low on the same edge;
  - ignored in WAIT_LOCK, STABLE and SW_RESET; there is no queuing.
- Lock loss:
  - locked_sync=0 in any state other than WAIT_LOCK -> WAIT_LOCK with counter=0, both resets low on that edge;
  - lock loss has priority over sw_reset_req and over any counter terminal count.
- Latency: with pll_locked held high, rstnn_core rises exactly SYNC_STAGES+LOCK_STABLE_CYCLES edges after the first edge that samples pll_locked=1. rstnn_peri rises CORE_TO_PERI_DELAY edges after rstnn_core.
- Glitch handling: a pll_locked glitch shorter than the synchroniser depth still increments lock_loss_count if it appears on locked_sync. Such a glitch restarts qualification from WAIT_LOCK.
- Invariant: rstnn_peri=1 implies rstnn_core=1 on every cycle; no transient violation is allowed.

Test Plan:
- Bench parameters: SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, CORE_TO_PERI_DELAY=4, SW_RESET_CYCLES=5.
- Cold start: hold rst=1 for 3 cycles, release, raise pll_locked at edge 10 -> rstnn_core=1 after edge 20, rstnn_peri=1 and system_ready=1 after edge 24, lock_loss_count=0.
- Unstable lock: pll_locked high for 5 cycles, low for 3, then high -> no reset release during the first pulse; lock_loss_count=1; rstnn_core rises 10 edges after the final rise.
- Software reset in RUN: pulse sw_reset_req for 1 cycle -> both resets low next edge and seq_state=4; rstnn_core high 5 edges later; rstnn_peri high 4 edges after that.
- Lock loss during SW_RESET with a simultaneous sw_reset_req -> state WAIT_LOCK, resets stay low, lock_loss_count increments by 1.
- Saturation: 300 lock/unlock cycles -> lock_loss_count stops at 255; rst=1 mid-sequence in CORE_RUN clears all outputs and the count to 0 on the next edge.

Source files
------------

// File: rtl/radarpim_reset_sequencer.sv
// Sequenced core/peripheral reset release behind the system PLL.
// Qualifies lock, releases core then peripherals, and handles warm resets and lock-loss counting.
module radarpim_reset_sequencer #(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int CORE_TO_PERI_DELAY = 16,
   parameter int SW_RESET_CYCLES    = 64,
   parameter int CNT_WIDTH          = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       sw_reset_req,
   output logic       rstnn_core,
   output logic       rstnn_peri,
   output logic       system_ready,
   output logic [7:0] lock_loss_count,
   output logic [2:0] seq_state
);

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABLE    = 3'd1,
      CORE_RUN  = 3'd2,
      RUN       = 3'd3,
      SW_RESET  = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] PERI_LAST = CNT_WIDTH'(CORE_TO_PERI_DELAY - 1);
   localparam logic [CNT_WIDTH-1:0] SW_LAST   = CNT_WIDTH'(SW_RESET_CYCLES - 1);

   state_t                 state, state_nxt;
   logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   locked_sync;
   logic                   locked_q;

   assign locked_sync = sync_q[SYNC_STAGES-1];
   assign seq_state   = state;

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
   end

   // Lock loss dominates everything; sw request beats terminal count in CORE_RUN.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         WAIT_LOCK: if (locked_sync) state_nxt = STABLE;
         STABLE: begin
            if (!locked_sync)          state_nxt = WAIT_LOCK;
            else if (cnt == LOCK_LAST) state_nxt = CORE_RUN;
            else                       cnt_nxt   = cnt + 1'b1;
         end
         CORE_RUN: begin
            if (!locked_sync)          state_nxt = WAIT_LOCK;
            else if (sw_reset_req)     state_nxt = SW_RESET;
            else if (cnt == PERI_LAST) state_nxt = RUN;
            else                       cnt_nxt   = cnt + 1'b1;
         end
         RUN: begin
            if (!locked_sync)      state_nxt = WAIT_LOCK;
            else if (sw_reset_req) state_nxt = SW_RESET;
         end
         SW_RESET: begin
            if (!locked_sync)        state_nxt = WAIT_LOCK;
            else if (cnt == SW_LAST) state_nxt = CORE_RUN;
            else                     cnt_nxt   = cnt + 1'b1;
         end
         default: state_nxt = WAIT_LOCK;
      endcase
   end

   // Outputs decode the next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= WAIT_LOCK;
         cnt             <= '0;
         locked_q        <= 1'b0;
         lock_loss_count <= 8'd0;
         rstnn_core      <= 1'b0;
         rstnn_peri      <= 1'b0;
         system_ready    <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         locked_q     <= locked_sync;
         rstnn_core   <= (state_nxt == CORE_RUN) || (state_nxt == RUN);
         rstnn_peri   <= (state_nxt == RUN);
         system_ready <= (state_nxt == RUN);
         if (locked_q && !locked_sync && (lock_loss_count != 8'hFF))
            lock_loss_count <= lock_loss_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_radarpim_reset_sequencer.sv
// Directed bench for radarpim_reset_sequencer: cold start, unstable lock, warm reset,
// lock loss during warm reset, and lock-loss counter saturation.
module tb_radarpim_reset_sequencer;
   localparam int SYNC = 2, LSC = 8, CPD = 4, SWC = 5;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       pll_locked = 1'b0;
   logic       sw_reset_req = 1'b0;
   logic       rstnn_core, rstnn_peri, system_ready;
   logic [7:0] lock_loss_count;
   logic [2:0] seq_state;
   int         checks = 0;
   int         passes = 0;

   radarpim_reset_sequencer #(
      .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LSC), .CORE_TO_PERI_DELAY(CPD),
      .SW_RESET_CYCLES(SWC), .CNT_WIDTH(16)
   ) dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
      .rstnn_core(rstnn_core), .rstnn_peri(rstnn_peri), .system_ready(system_ready),
      .lock_loss_count(lock_loss_count), .seq_state(seq_state)
   );

   always #5 clk = ~clk;

   // Peripherals must never be out of reset while the core is held.
   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if (rstnn_peri && !rstnn_core)
            $display("FAIL invariant: peri=%b core=%b required core=1", rstnn_peri, rstnn_core);
         else passes++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1; pll_locked = 1'b0; sw_reset_req = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (rstnn_core !== 1'b0) $display("FAIL reset_core: got %b want 0", rstnn_core); else passes++;
      checks++; if (rstnn_peri !== 1'b0) $display("FAIL reset_peri: got %b want 0", rstnn_peri); else passes++;
      checks++; if (system_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", system_ready); else passes++;
      checks++; if (seq_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", seq_state); else passes++;
      checks++; if (lock_loss_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", lock_loss_count); else passes++;
      rst = 1'b0;
   endtask

   task automatic test_cold_start();
      repeat (6) tick();
      checks++; if (seq_state !== 3'd0) $display("FAIL cold_idle_state: got %0d want 0", seq_state); else passes++;
      pll_locked = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 3) begin
            checks++; if (seq_state !== 3'd1) $display("FAIL cold_stable_state: got %0d want 1", seq_state); else passes++;
         end
         if (i == 10) begin
            checks++; if (rstnn_core !== 1'b0) $display("FAIL cold_core_early: got %b want 0", rstnn_core); else passes++;
         end
         if (i == 11) begin
            checks++; if (rstnn_core !== 1'b1) $display("FAIL cold_core_rise: got %b want 1", rstnn_core); else passes++;
            checks++; if (seq_state !== 3'd2) $display("FAIL cold_core_state: got %0d want 2", seq_state); else passes++;
         end
         if (i == 14) begin
            checks++; if (rstnn_peri !== 1'b0) $display("FAIL cold_peri_early: got %b want 0", rstnn_peri); else passes++;
         end
         if (i == 15) begin
            checks++; if (rstnn_peri !== 1'b1) $display("FAIL cold_peri_rise: got %b want 1", rstnn_peri); else passes++;
            checks++; if (system_ready !== 1'b1) $display("FAIL cold_ready: got %b want 1", system_ready); else passes++;
            checks++; if (seq_state !== 3'd3) $display("FAIL cold_run_state: got %0d want 3", seq_state); else passes++;
         end
      end
      checks++; if (lock_loss_count !== 8'd0) $display("FAIL cold_count: got %0d want 0", lock_loss_count); else passes++;
   endtask

   task automatic test_unstable_lock();
      apply_reset();
      pll_locked = 1'b1;
      repeat (5) tick();
      checks++; if (seq_state !== 3'd1) $display("FAIL unstable_first_state: got %0d want 1", seq_state); else passes++;
      checks++; if (rstnn_core !== 1'b0) $display("FAIL unstable_first_core: got %b want 0", rstnn_core); else passes++;
      pll_locked = 1'b0;
      repeat (3) tick();
      checks++; if (seq_state !== 3'd0) $display("FAIL unstable_drop_state: got %0d want 0", seq_state); else passes++;
      checks++; if (rstnn_core !== 1'b0) $display("FAIL unstable_drop_core: got %b want 0", rstnn_core); else passes++;
      checks++; if (lock_loss_count !== 8'd1) $display("FAIL unstable_count: got %0d want 1", lock_loss_count); else passes++;
      pll_locked = 1'b1;
      for (int j = 1; j <= 15; j++) begin
         tick();
         if (j == 10) begin
            checks++; if (rstnn_core !== 1'b0) $display("FAIL unstable_core_early: got %b want 0", rstnn_core); else passes++;
         end
         if (j == 11) begin
            checks++; if (rstnn_core !== 1'b1) $display("FAIL unstable_core_rise: got %b want 1", rstnn_core); else passes++;
         end
         if (j == 15) begin
            checks++; if (system_ready !== 1'b1) $display("FAIL unstable_ready: got %b want 1", system_ready); else passes++;
         end
      end
   endtask

   task automatic test_sw_reset();
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      checks++; if (rstnn_core !== 1'b0) $display("FAIL sw_core_low: got %b want 0", rstnn_core); else passes++;
      checks++; if (rstnn_peri !== 1'b0) $display("FAIL sw_peri_low: got %b want 0", rstnn_peri); else passes++;
      checks++; if (system_ready !== 1'b0) $display("FAIL sw_ready_low: got %b want 0", system_ready); else passes++;
      checks++; if (seq_state !== 3'd4) $display("FAIL sw_state: got %0d want 4", seq_state); else passes++;
      for (int k = 1; k <= 9; k++) begin
         sw_reset_req = (k == 2);   // a repeat request inside SW_RESET must not restart it
         tick();
         sw_reset_req = 1'b0;
         if (k == 4) begin
            checks++; if (rstnn_core !== 1'b0) $display("FAIL sw_core_early: got %b want 0", rstnn_core); else passes++;
            checks++; if (seq_state !== 3'd4) $display("FAIL sw_hold_state: got %0d want 4", seq_state); else passes++;
         end
         if (k == 5) begin
            checks++; if (rstnn_core !== 1'b1) $display("FAIL sw_core_rise: got %b want 1", rstnn_core); else passes++;
            checks++; if (seq_state !== 3'd2) $display("FAIL sw_core_state: got %0d want 2", seq_state); else passes++;
         end
         if (k == 8) begin
            checks++; if (rstnn_peri !== 1'b0) $display("FAIL sw_peri_early: got %b want 0", rstnn_peri); else passes++;
         end
         if (k == 9) begin
            checks++; if (rstnn_peri !== 1'b1) $display("FAIL sw_peri_rise: got %b want 1", rstnn_peri); else passes++;
            checks++; if (system_ready !== 1'b1) $display("FAIL sw_ready: got %b want 1", system_ready); else passes++;
         end
      end
   endtask

   task automatic test_lock_loss_in_sw_reset();
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      checks++; if (seq_state !== 3'd4) $display("FAIL loss_enter_sw: got %0d want 4", seq_state); else passes++;
      pll_locked = 1'b0;
      tick(); tick();
      sw_reset_req = 1'b1;
      tick();
      sw_reset_req = 1'b0;
      checks++; if (seq_state !== 3'd0) $display("FAIL loss_state: got %0d want 0", seq_state); else passes++;
      checks++; if (rstnn_core !== 1'b0) $display("FAIL loss_core: got %b want 0", rstnn_core); else passes++;
      checks++; if (rstnn_peri !== 1'b0) $display("FAIL loss_peri: got %b want 0", rstnn_peri); else passes++;
      checks++; if (lock_loss_count !== 8'd2) $display("FAIL loss_count: got %0d want 2", lock_loss_count); else passes++;
      tick();
      checks++; if (seq_state !== 3'd0) $display("FAIL loss_no_queue: got %0d want 0", seq_state); else passes++;
   endtask

   task automatic test_saturation();
      apply_reset();
      for (int n = 1; n <= 300; n++) begin
         pll_locked = 1'b1; tick();
         pll_locked = 1'b0; tick();
         if (n == 10) begin
            checks++; if (lock_loss_count !== 8'd9) $display("FAIL sat_partial: got %0d want 9", lock_loss_count); else passes++;
         end
      end
      checks++; if (lock_loss_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", lock_loss_count); else passes++;
      pll_locked = 1'b1;
      repeat (12) tick();
      checks++; if (seq_state !== 3'd2) $display("FAIL sat_core_run: got %0d want 2", seq_state); else passes++;
      checks++; if (lock_loss_count !== 8'd255) $display("FAIL sat_hold: got %0d want 255", lock_loss_count); else passes++;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (rstnn_core !== 1'b0) $display("FAIL midrst_core: got %b want 0", rstnn_core); else passes++;
      checks++; if (rstnn_peri !== 1'b0) $display("FAIL midrst_peri: got %b want 0", rstnn_peri); else passes++;
      checks++; if (system_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", system_ready); else passes++;
      checks++; if (seq_state !== 3'd0) $display("FAIL midrst_state: got %0d want 0", seq_state); else passes++;
      checks++; if (lock_loss_count !== 8'd0) $display("FAIL midrst_count: got %0d want 0", lock_loss_count); else passes++;
   endtask

   initial begin
      test_reset();
      test_cold_start();
      test_unstable_lock();
      test_sw_reset();
      test_lock_loss_in_sw_reset();
      test_saturation();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
